// File: rtl/sprite_index_pipe.sv
// Sprite compositor: maps the VGA draw stream to a 6-bit palette address with
// up to NUM_SPRITES 16x16 sprites over a flat background, double-buffered attributes.

module sprite_index_slot #(
   parameter int SPR_W = 16,
   parameter int SPR_H = 16,
   parameter int XB    = 4,
   parameter int YB    = 4,
   parameter int AW    = 2 + YB + XB
) (
   input  logic          en,
   input  logic [9:0]    sx,
   input  logic [9:0]    sy,
   input  logic [1:0]    frame,
   input  logic [9:0]    px,
   input  logic [9:0]    py,
   output logic          hit,
   output logic [AW-1:0] addr
);
   logic [XB-1:0] ox;
   logic [YB-1:0] oy;

   // 11-bit right/bottom bounds keep a sprite near 1023 from wrapping to 0
   assign hit = en && (px >= sx) && ({1'b0, px} < ({1'b0, sx} + 11'(SPR_W)))
                   && (py >= sy) && ({1'b0, py} < ({1'b0, sy} + 11'(SPR_H)));
   assign ox   = px[XB-1:0] - sx[XB-1:0];
   assign oy   = py[YB-1:0] - sy[YB-1:0];
   assign addr = hit ? {frame, oy, ox} : '0;
endmodule

module sprite_index_pipe #(
   parameter int         NUM_SPRITES  = 4,
   parameter int         SPR_W        = 16,
   parameter int         SPR_H        = 16,
   parameter logic [5:0] TRANSP_INDEX = 6'd0,
   parameter logic [5:0] BG_INDEX     = 6'd30,
   localparam int IDW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
   localparam int XB  = $clog2(SPR_W),
   localparam int YB  = $clog2(SPR_H),
   localparam int AW  = 2 + YB + XB
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic [9:0]                draw_x,
   input  logic [9:0]                draw_y,
   input  logic                      de_in,
   input  logic                      hs_in,
   input  logic                      vs_in,
   input  logic                      attr_valid,
   output logic                      attr_ready,
   input  logic [IDW-1:0]            attr_id,
   input  logic [9:0]                attr_x,
   input  logic [9:0]                attr_y,
   input  logic                      attr_en,
   input  logic [1:0]                attr_frame,
   output logic [NUM_SPRITES*AW-1:0] spr_rom_addr,
   input  logic [NUM_SPRITES*6-1:0]  spr_rom_data,
   output logic [5:0]                palette_addr,
   output logic                      de_out,
   output logic                      hs_out,
   output logic                      vs_out
);
   typedef struct packed {
      logic       en;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] frame;
   } attr_t;

   typedef enum logic {ACCEPT, COPY} state_t;

   localparam logic [IDW:0] NSLOT = (IDW+1)'(NUM_SPRITES);

   attr_t [NUM_SPRITES-1:0] act, pend;
   state_t state, state_n;
   logic   dirty, ready_q, xfer, id_ok, vs_fall;

   logic [9:0] px, py;
   logic [3:0] de_p, hs_p, vs_p;
   logic [NUM_SPRITES-1:0]         hit_c, hit1, hit2;
   logic [NUM_SPRITES-1:0][AW-1:0] addr_c, addr_q;
   logic [NUM_SPRITES-1:0][5:0]    rdat;
   logic [5:0] pix_c, pal_q;
   logic       found;

   assign rdat         = spr_rom_data;
   assign spr_rom_addr = addr_q;
   assign palette_addr = pal_q;
   assign de_out       = de_p[3];
   assign hs_out       = hs_p[3];
   assign vs_out       = vs_p[3];
   assign attr_ready   = ready_q;
   assign xfer         = attr_valid && ready_q;
   assign id_ok        = {1'b0, attr_id} < NSLOT;
   // vs_p[0] is the registered vs_in, vs_p[1] its previous value
   assign vs_fall      = vs_p[1] && !vs_p[0];

   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
      sprite_index_slot #(.SPR_W(SPR_W), .SPR_H(SPR_H), .XB(XB), .YB(YB), .AW(AW)) u_slot (
         .en    (act[i].en),
         .sx    (act[i].x),
         .sy    (act[i].y),
         .frame (act[i].frame),
         .px    (px),
         .py    (py),
         .hit   (hit_c[i]),
         .addr  (addr_c[i])
      );
   end

   // lowest slot index with an opaque pixel wins
   always_comb begin
      pix_c = BG_INDEX;
      found = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (!found && hit2[i] && rdat[i] != TRANSP_INDEX) begin
            pix_c = rdat[i];
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         px     <= '0;
         py     <= '0;
         de_p   <= '0;
         hs_p   <= '1;
         vs_p   <= '1;
         hit1   <= '0;
         hit2   <= '0;
         addr_q <= '0;
         pal_q  <= '0;
      end else begin
         px     <= draw_x;
         py     <= draw_y;
         de_p   <= {de_p[2:0], de_in};
         hs_p   <= {hs_p[2:0], hs_in};
         vs_p   <= {vs_p[2:0], vs_in};
         hit1   <= hit_c;
         addr_q <= addr_c;
         hit2   <= hit1;
         pal_q  <= de_p[2] ? pix_c : 6'd0;
      end
   end

   // a transfer on the detecting edge is already counted in dirty's intent
   always_comb begin
      state_n = state;
      case (state)
         ACCEPT:  if (vs_fall && (dirty || (xfer && id_ok))) state_n = COPY;
         COPY:    state_n = ACCEPT;
         default: state_n = ACCEPT;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= ACCEPT;
         ready_q <= 1'b0;
      end else begin
         state   <= state_n;
         ready_q <= (state_n == ACCEPT);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         act   <= '0;
         pend  <= '0;
         dirty <= 1'b0;
      end else begin
         if (xfer && id_ok) begin
            pend[attr_id] <= {attr_en, attr_x, attr_y, attr_frame};
            dirty         <= 1'b1;
         end
         if (state == COPY) begin
            act   <= pend;
            dirty <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sprite_index_pipe.sv
// Directed bench for sprite_index_pipe with a registered sprite ROM model and
// a cycle-stamped scoreboard of expected outputs.

module tb_sprite_index_pipe;
   localparam int NS  = 5;
   localparam int AW  = 10;
   localparam int IDW = 3;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic [9:0] draw_x = '0, draw_y = '0;
   logic de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
   logic attr_valid = 1'b0;
   logic attr_ready;
   logic [IDW-1:0] attr_id = '0;
   logic [9:0] attr_x = '0, attr_y = '0;
   logic attr_en = 1'b0;
   logic [1:0] attr_frame = '0;
   logic [NS*AW-1:0] spr_rom_addr;
   logic [NS*6-1:0]  spr_rom_data;
   logic [5:0] palette_addr;
   logic de_out, hs_out, vs_out;

   sprite_index_pipe #(.NUM_SPRITES(NS)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .draw_x(draw_x), .draw_y(draw_y), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
      .attr_valid(attr_valid), .attr_ready(attr_ready), .attr_id(attr_id),
      .attr_x(attr_x), .attr_y(attr_y), .attr_en(attr_en), .attr_frame(attr_frame),
      .spr_rom_addr(spr_rom_addr), .spr_rom_data(spr_rom_data),
      .palette_addr(palette_addr), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // per-slot ROM returns a bench-chosen value, one cycle after the address
   logic [5:0] rom_val [NS];
   logic [NS-1:0][5:0] rom_q;
   always @(posedge Clk) for (int i = 0; i < NS; i++) rom_q[i] <= rom_val[i];
   assign spr_rom_data = rom_q;

   typedef struct {
      int         due;
      int         kind;   // 0: {de,hs,vs,palette}; k>0: rom address of slot k-1
      logic [9:0] exp;
      string      tag;
   } chk_t;
   chk_t sbq[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge Clk) begin : mon
      int i;
      logic [9:0] obs;
      i = 0;
      while (i < sbq.size()) begin
         if (sbq[i].due == cyc) begin
            if (sbq[i].kind == 0) obs = {1'b0, de_out, hs_out, vs_out, palette_addr};
            else                  obs = spr_rom_addr[(sbq[i].kind-1)*AW +: AW];
            chk(sbq[i].tag, 32'(obs), 32'(sbq[i].exp));
            sbq.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic drive(input int x, input int y, input logic de, input logic hs, input logic vs);
      @(posedge Clk); #1;
      draw_x = 10'(x); draw_y = 10'(y); de_in = de; hs_in = hs; vs_in = vs;
   endtask

   task automatic push(input string tag, input int due, input int kind, input logic [9:0] exp);
      chk_t c;
      c.due = due; c.kind = kind; c.exp = exp; c.tag = tag;
      sbq.push_back(c);
   endtask

   task automatic pix(input string tag, input int x, input int y, input logic de, input logic [5:0] pal);
      drive(x, y, de, 1'b1, 1'b1);
      push(tag, cyc + 4, 0, {1'b0, de, 2'b11, pal});
   endtask

   task automatic addr_chk(input string tag, input int x, input int y, input int slot, input logic [9:0] exp);
      drive(x, y, 1'b1, 1'b1, 1'b1);
      push(tag, cyc + 2, slot + 1, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic wr(input int id, input int x, input int y, input logic en, input logic [1:0] fr);
      int k;
      @(posedge Clk); #1;
      attr_id = IDW'(id); attr_x = 10'(x); attr_y = 10'(y); attr_en = en; attr_frame = fr;
      attr_valid = 1'b1;
      k = 0;
      while (!attr_ready && k < 20) begin
         @(posedge Clk); #1;
         k++;
      end
      chk("wr_handshake", 32'(attr_ready), 32'd1);
      @(posedge Clk); #1;
      attr_valid = 1'b0;
   endtask

   task automatic vsync();
      repeat (4) drive(0, 0, 1'b0, 1'b1, 1'b0);
      idle(4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NS; i++) rom_val[i] = 6'd0;

      // reset held with stimulus running
      repeat (4) drive(103, 55, 1'b1, 1'b0, 1'b0);
      @(negedge Clk);
      chk("rst_pal",   32'(palette_addr), 32'd0);
      chk("rst_hs",    32'(hs_out), 32'd1);
      chk("rst_vs",    32'(vs_out), 32'd1);
      chk("rst_de",    32'(de_out), 32'd0);
      chk("rst_ready", 32'(attr_ready), 32'd0);
      chk("rst_addr",  32'(spr_rom_addr == '0), 32'd1);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      chk("ready_at_release", 32'(attr_ready), 32'd0);
      @(posedge Clk); #1;
      chk("ready_after_edge", 32'(attr_ready), 32'd1);
      idle(5);

      // background only, then blanking with sync alignment
      for (int x = 0; x < 640; x++) pix("bg", x, 10, 1'b1, 6'd30);
      pix("blank", 5, 10, 1'b0, 6'd0);
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      push("hs_align", cyc + 4, 0, {1'b0, 1'b0, 1'b0, 1'b1, 6'd0});
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      push("vs_align", cyc + 4, 0, {1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
      idle(6);

      // slot 1 at (100,50), frame 2
      wr(1, 100, 50, 1'b1, 2'd2);
      vsync();
      rom_val[1] = 6'd17;
      idle(3);
      addr_chk("addr_s1", 103, 55, 1, 10'h253);
      addr_chk("addr_s1_miss", 99, 55, 1, 10'h000);
      pix("s1_hit", 103, 55, 1'b1, 6'd17);
      pix("s1_left", 99, 55, 1'b1, 6'd30);
      pix("s1_tl", 100, 50, 1'b1, 6'd17);
      pix("s1_br", 115, 65, 1'b1, 6'd17);
      pix("s1_right", 116, 55, 1'b1, 6'd30);
      pix("s1_below", 103, 66, 1'b1, 6'd30);
      pix("s1_above", 103, 49, 1'b1, 6'd30);
      idle(6);
      rom_val[1] = 6'd0;
      idle(3);
      pix("s1_transp", 103, 55, 1'b1, 6'd30);
      idle(6);

      // overlap priority: slots 0 and 2 on the same pixel
      wr(0, 100, 50, 1'b1, 2'd0);
      wr(2, 100, 50, 1'b1, 2'd1);
      vsync();
      rom_val[0] = 6'd12; rom_val[2] = 6'd22;
      idle(3);
      pix("prio_s0", 103, 55, 1'b1, 6'd12);
      idle(6);
      rom_val[0] = 6'd0;
      idle(3);
      pix("prio_s2", 103, 55, 1'b1, 6'd22);
      idle(6);
      rom_val[0] = 6'd12; rom_val[3] = 6'd33;
      idle(3);

      // mid-frame move holds until vsync; write held across COPY lands a frame later
      wr(0, 200, 50, 1'b1, 2'd0);
      pix("move_old", 103, 55, 1'b1, 6'd12);
      pix("move_new_pre", 203, 55, 1'b1, 6'd30);
      idle(6);
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      chk("rdy_pre_copy", 32'(attr_ready), 32'd1);
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      chk("rdy_copy", 32'(attr_ready), 32'd0);
      attr_id = 3'd3; attr_x = 10'd300; attr_y = 10'd50; attr_en = 1'b1; attr_frame = 2'd0;
      attr_valid = 1'b1;
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      chk("rdy_back", 32'(attr_ready), 32'd1);
      drive(0, 0, 1'b0, 1'b1, 1'b1);
      attr_valid = 1'b0;
      chk("rdy_after", 32'(attr_ready), 32'd1);
      idle(4);
      pix("moved_new", 203, 55, 1'b1, 6'd12);
      pix("moved_old", 103, 55, 1'b1, 6'd22);
      pix("held_pending", 303, 55, 1'b1, 6'd30);
      idle(6);
      vsync();
      pix("held_active", 303, 55, 1'b1, 6'd33);
      idle(6);

      // right-edge sprite must not wrap to column 0
      wr(4, 1020, 100, 1'b1, 2'd0);
      rom_val[4] = 6'd44;
      vsync();
      pix("edge_1020", 1020, 105, 1'b1, 6'd44);
      pix("edge_1023", 1023, 105, 1'b1, 6'd44);
      pix("edge_1019", 1019, 105, 1'b1, 6'd30);
      pix("wrap_0", 0, 105, 1'b1, 6'd30);
      pix("wrap_3", 3, 105, 1'b1, 6'd30);
      pix("wrap_11", 11, 105, 1'b1, 6'd30);
      addr_chk("addr_edge", 1023, 105, 4, 10'h053);
      addr_chk("addr_wrap", 0, 105, 4, 10'h000);
      idle(6);

      // out-of-range id: accepted, discarded, no COPY
      wr(5, 0, 0, 1'b1, 2'd0);
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      chk("badid_rdy1", 32'(attr_ready), 32'd1);
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      chk("badid_rdy2", 32'(attr_ready), 32'd1);
      drive(0, 0, 1'b0, 1'b1, 1'b1);
      chk("badid_rdy3", 32'(attr_ready), 32'd1);
      idle(4);
      pix("badid_nochange", 5, 5, 1'b1, 6'd30);
      idle(6);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      // reset mid-stream forces outputs at once
      repeat (5) drive(103, 55, 1'b1, 1'b1, 1'b1);
      @(negedge Clk);
      chk("pre_rst_pal", 32'(palette_addr), 32'd22);
      Reset_n = 1'b0;
      #1;
      chk("midrst_pal",   32'(palette_addr), 32'd0);
      chk("midrst_de",    32'(de_out), 32'd0);
      chk("midrst_ready", 32'(attr_ready), 32'd0);
      repeat (2) @(posedge Clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
